// File: rtl/averages_pkg.sv
// Constants and FSM state type shared by the byte packer and the 64-bit serializer.
package averages_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NBYTES = 8;
  localparam int unsigned WORD_W = BYTE_W * NBYTES;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

endpackage

// File: rtl/byte_lane_writer.sv
// Combinational lane insert: writes one byte into lane `lane` of the accumulator.
// Lane 0 is the most significant byte.
module byte_lane_writer #(
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned NBYTES = 8,
  parameter int unsigned IDX_W  = 8
) (
  input  logic [BYTE_W*NBYTES-1:0] acc,
  input  logic [IDX_W-1:0]         lane,
  input  logic [BYTE_W-1:0]        data,
  output logic [BYTE_W*NBYTES-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (lane == IDX_W'(i)) begin
        acc_next[BYTE_W*(NBYTES-i)-1 -: BYTE_W] = data;
      end
    end
  end

endmodule

// File: rtl/byte_packer_64.sv
// Packs a valid/ready byte stream MSB-first into words; a word closes when full
// or on in_last, and is held in the output register until the consumer takes it.
module byte_packer_64 #(
  parameter int unsigned BYTE_W = averages_pkg::BYTE_W,
  parameter int unsigned NBYTES = averages_pkg::NBYTES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BYTE_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [BYTE_W*NBYTES-1:0] out_data,
  output logic [3:0]               out_nbytes,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               count,
  output logic [7:0]               word_count
);
  import averages_pkg::*;

  localparam int unsigned WORD_W = BYTE_W * NBYTES;

  pack_state_t       state;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_next;
  logic              accept;
  logic              close;

  // Ready depends on the state register alone, never on out_ready.
  assign in_ready = (state == FILL);
  assign accept   = in_valid & in_ready;
  assign close    = accept & (in_last | (count == 8'(NBYTES - 1)));

  byte_lane_writer #(
    .BYTE_W (BYTE_W),
    .NBYTES (NBYTES),
    .IDX_W  (8)
  ) u_lane_writer (
    .acc      (acc),
    .lane     (count),
    .data     (in_data),
    .acc_next (acc_next)
  );

  // Accumulator is cleared on every close, so unwritten lanes of a short word read as 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FILL;
      acc        <= '0;
      count      <= 8'd0;
      word_count <= 8'd0;
      out_data   <= '0;
      out_nbytes <= 4'd0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (close) begin
            out_data   <= acc_next;
            out_nbytes <= 4'(count + 8'd1);
            out_valid  <= 1'b1;
            count      <= 8'd0;
            acc        <= '0;
            state      <= HOLD;
          end else if (accept) begin
            acc   <= acc_next;
            count <= count + 8'd1;
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
            word_count <= word_count + 8'd1;
            state      <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_packer_64.sv
// Directed-vector bench for byte_packer_64 with hand-computed expected words.
module tb_byte_packer_64;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [63:0] out_data;
  logic [3:0]  out_nbytes;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  count;
  logic [7:0]  word_count;

  int n_vec = 0;
  int n_err = 0;

  byte_packer_64 dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_nbytes (out_nbytes),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assert property (@(posedge clk) disable iff (!rst) (out_valid && !out_ready) |=> out_valid)
    else $error("out_valid dropped before handshake");
  assert property (@(posedge clk) disable iff (!rst) (out_valid && !out_ready) |=> $stable(out_data))
    else $error("out_data changed while stalled");

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte and return 1 time unit after the edge that accepts it.
  task automatic push(input logic [7:0] b, input logic last);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("push_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] exp_word;

  initial begin
    rst = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_data",   out_data,          64'd0);
    check("rst_out_nbytes", 64'(out_nbytes),   64'd0);
    check("rst_out_valid",  64'(out_valid),    64'd0);
    check("rst_count",      64'(count),        64'd0);
    check("rst_word_count", 64'(word_count),   64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Full word
    push(8'hF0, 1'b0); push(8'hCE, 1'b0); push(8'hFC, 1'b0); push(8'h0B, 1'b0);
    push(8'hF0, 1'b0); push(8'hCE, 1'b0); push(8'hFC, 1'b0); push(8'h05, 1'b0);
    check("full_data",     out_data,        64'hF0CEFC0BF0CEFC05);
    check("full_nbytes",   64'(out_nbytes), 64'd8);
    check("full_valid",    64'(out_valid),  64'd1);
    check("full_in_ready", 64'(in_ready),   64'd0);
    tick();
    check("full_wc",       64'(word_count), 64'd1);
    check("full_valid_lo", 64'(out_valid),  64'd0);
    check("full_ready_hi", 64'(in_ready),   64'd1);

    // Partial word, with an in_last that has no in_valid in between
    push(8'hAA, 1'b0);
    in_last = 1'b1;
    tick();
    in_last = 1'b0;
    check("lastnovalid_count", 64'(count),     64'd1);
    check("lastnovalid_valid", 64'(out_valid), 64'd0);
    push(8'hBB, 1'b0);
    check("part_count2", 64'(count), 64'd2);
    push(8'hCC, 1'b1);
    check("part_data",   out_data,        64'hAABBCC0000000000);
    check("part_nbytes", 64'(out_nbytes), 64'd3);
    check("part_count",  64'(count),      64'd0);
    tick();
    check("part_wc", 64'(word_count), 64'd2);

    // Backpressure
    out_ready = 1'b0;
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b0);
    push(8'h55, 1'b0); push(8'h66, 1'b0); push(8'h77, 1'b0); push(8'h88, 1'b0);
    check("bp_data0", out_data, 64'h1122334455667788);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", 64'(in_ready),  64'd0);
      check("bp_valid",    64'(out_valid), 64'd1);
      check("bp_data",     out_data,       64'h1122334455667788);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h99;
    tick();
    check("bp_hs_valid", 64'(out_valid),  64'd0);
    check("bp_hs_count", 64'(count),      64'd0);
    check("bp_hs_wc",    64'(word_count), 64'd3);
    tick();
    in_valid = 1'b0;
    check("bp_next_count", 64'(count), 64'd1);
    push(8'h9A, 1'b1);
    check("bp_next_data",   out_data,        64'h999A000000000000);
    check("bp_next_nbytes", 64'(out_nbytes), 64'd2);
    tick();
    check("bp_next_wc", 64'(word_count), 64'd4);

    // Bubbles
    for (int i = 1; i <= 8; i++) begin
      check("bub_count", 64'(count), 64'(i - 1));
      push(8'(i), 1'b0);
      if (i < 8) tick();
    end
    check("bub_data",   out_data,        64'h0102030405060708);
    check("bub_nbytes", 64'(out_nbytes), 64'd8);
    tick();
    check("bub_wc", 64'(word_count), 64'd5);

    // in_last on lane 7 closes exactly one word
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i), (i == 7));
    check("l7_data",   out_data,        64'h1011121314151617);
    check("l7_nbytes", 64'(out_nbytes), 64'd8);
    tick();
    tick();
    check("l7_valid", 64'(out_valid),  64'd0);
    check("l7_wc",    64'(word_count), 64'd6);
    check("l7_count", 64'(count),      64'd0);

    // Reset mid-word, asserted between edges
    push(8'hE1, 1'b0); push(8'hE2, 1'b0); push(8'hE3, 1'b0); push(8'hE4, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_count", 64'(count),      64'd0);
    check("mrst_valid", 64'(out_valid),  64'd0);
    check("mrst_wc",    64'(word_count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'hA1 + i), 1'b0);
    check("mrst_data", out_data, 64'hA1A2A3A4A5A6A7A8);
    tick();
    check("mrst_wc1", 64'(word_count), 64'd1);

    // Wrap: fresh reset, then 256 single-byte words
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      push(8'(i ^ 8'h5A), 1'b1);
      exp_word = {8'(i ^ 8'h5A), 56'd0};
      check("wrap_data",   out_data,        exp_word);
      check("wrap_nbytes", 64'(out_nbytes), 64'd1);
      tick();
    end
    check("wrap_wc", 64'(word_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/byte_packer_64.md
# byte_packer_64

Assembles a stream of 8-bit bytes into 64-bit words. It is the receive-side counterpart of the team's 64-bit-to-byte shifting register, sitting between the byte-serial link and the 64-bit averaging datapath. Bytes arrive under a valid/ready handshake and are packed MSB-first. Each completed word, or a partial word closed early by `in_last`, is held in an output register until the downstream consumer accepts it.

## Interface
Parameters:
- `BYTE_W`, default 8: width of one input beat.
- `NBYTES`, default 8: beats per output word. Output width is `BYTE_W*NBYTES` (64 by default).

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst`, in, 1: reset, asynchronous assert, active-low (0 = reset).
- `in_data`, in, 8: input byte.
- `in_valid`, in, 1: `in_data` and `in_last` are valid.
- `in_last`, in, 1: the accompanying byte closes the current word.
- `in_ready`, out, 1: packer can accept a byte this cycle.
- `out_data`, out, 64: packed word.
- `out_nbytes`, out, 4: number of valid bytes in `out_data`, range 1..8.
- `out_valid`, out, 1: `out_data` and `out_nbytes` are valid.
- `out_ready`, in, 1: consumer accepts the word.
- `count`, out, 8: bytes accumulated in the current word, range 0..7.
- `word_count`, out, 8: words delivered since reset; wraps mod 256.

## Operation
- **FSM states:** FILL and HOLD. Reset state is FILL.
- **FILL:**
  - `in_ready` = 1.
  - An input is accepted when `in_valid & in_ready`.
  - The accepted byte is written to byte lane `count`, which occupies bits `[63-8*count -: 8]`. The first byte lands in `[63:56]`.
- **Word close:** a word closes when the accepted byte is lane 7, or when `in_last` = 1. On close:
  - `out_data` ← the assembled word, with unwritten lanes forced to 0.
  - `out_nbytes` ← `count+1`.
  - `out_valid` ← 1.
  - `count` ← 0, and the accumulator is cleared.
  - The FSM moves to HOLD.
- **Non-closing accept:** `count` ← `count+1`.
- **HOLD:**
  - `in_ready` = 0; no bytes are accepted.
  - `out_data` and `out_nbytes` stay stable while `out_valid` = 1 and `out_ready` = 0.
  - On `out_valid & out_ready`: `out_valid` ← 0, `word_count` ← `word_count+1` (255 wraps to 0), and the FSM moves to FILL.
- **`in_valid` low in FILL:** no state change; a partial word is held indefinitely.
- **`in_last` with `in_valid` = 0:** ignored.
- **`in_last` on lane 7:** a single close with `out_nbytes` = 8, not two words.
- **Reset at any point:** a partial word or an un-accepted output is discarded.

## Timing
- **Reset values:**
  - `out_data` = 0, `out_nbytes` = 0, `out_valid` = 0.
  - `count` = 0, `word_count` = 0.
  - `in_ready` = 1 as soon as `rst` deasserts.
- **Latency:** `out_valid` rises on the clock edge that accepts the closing byte.
- **Acceptance:** the word is consumed on the edge where `out_valid & out_ready`. `in_ready` returns to 1 on the following cycle.
- **Throughput:** with `in_valid` and `out_ready` held high, a full word takes 9 cycles: 8 fill cycles plus 1 hold cycle.
- **Combinational paths:** `in_ready` is decoded from the state register only. There is no combinational path from `out_ready` to `in_ready`.
- **Protocol checks (verification asserts):**
  - Once `out_valid` = 1, it must not drop before the handshake completes.
  - `out_data` must not change while `out_valid & !out_ready`.

## Structure
- **Shared package** (`averages_pkg`): the FSM state enum (FILL, HOLD), `BYTE_W`, `NBYTES`, and the derived `WORD_W` constant. The serializer uses the same constants.
- **Sub-module:** `byte_lane_writer` (combinational), which takes the accumulator, lane index, and byte and returns the updated accumulator.
- The FSM, the counters, and the output register stay in the top module.

## Test plan
1. **Full word:**
   - Stimulus: reset low for 2 cycles, then release. Stream bytes F0,CE,FC,0B,F0,CE,FC,05 with `out_ready` = 1.
   - Required: `out_data` = F0CEFC0BF0CEFC05 and `out_nbytes` = 8 on the edge after the 8th byte; `word_count` = 1 afterwards.
2. **Partial word:**
   - Stimulus: bytes AA,BB,CC with `in_last` set on CC.
   - Required: `out_data` = AABBCC0000000000, `out_nbytes` = 3, `count` = 0.
3. **Backpressure:**
   - Stimulus: complete a word with `out_ready` = 0 for 5 cycles.
   - Required: `in_ready` = 0 and `out_data` stable throughout; the next word's first byte is accepted only on the cycle after `out_ready` = 1.
4. **Bubbles:**
   - Stimulus: `in_valid` toggled every other cycle across 8 bytes 01..08.
   - Required: `out_data` = 0102030405060708 and `count` steps 0..7.
5. **Reset mid-word:**
   - Stimulus: after 4 bytes, assert `rst` = 0 asynchronously between clock edges.
   - Required: `count`, `out_valid`, and `word_count` go to 0 immediately; the next 8 bytes form a clean word.
6. **Wrap:**
   - Stimulus: 256 single-byte words, each with `in_last` = 1.
   - Required: `word_count` returns to 0; every output has `out_nbytes` = 1 and the data in `[63:56]` only.
